// File: rtl/mem_write_tracer.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_tracer
// Purpose  : Snoops the data-memory write port and records qualifying
//            {addr,data} writes into a DEPTH-entry show-ahead FIFO. Capture
//            is gated by an IDLE/CAPTURE/FROZEN state machine. The FIFO
//            drains over a valid/ready interface. Writes lost to a full FIFO
//            are counted with a saturating counter and a sticky flag.
// Ports    :
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high
//   wr_en_i        in   data-memory write strobe
//   wr_addr_i      in   [ADDR_W]  write address
//   wr_data_i      in   [DATA_W]  write data
//   arm_i          in   pulse: start/resume capture
//   clear_i        in   pulse: flush FIFO, zero counters, go IDLE
//   stop_en_i      in   1: a write to stop_addr_i ends capture
//   stop_addr_i    in   [ADDR_W]  address that freezes capture
//   out_valid_o    out  FIFO head valid
//   out_ready_i    in   consumer accepts head
//   out_data_o     out  [ADDR_W+DATA_W] head entry, addr in MSBs
//   level_o        out  [$clog2(DEPTH+1)] entries held
//   drop_count_o   out  [CNT_W] qualifying writes lost, saturating
//   overflow_o     out  sticky: at least one drop since clear/reset
//   state_o        out  [2] 00 IDLE, 01 CAPTURE, 10 FROZEN
// Revision : 1.0 - initial release
// ============================================================================
module mem_write_tracer #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 24,
    parameter int DEPTH       = 16,
    parameter int FILTER_ZERO = 1,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         arm_i,
    input  logic                         clear_i,
    input  logic                         stop_en_i,
    input  logic [ADDR_W-1:0]            stop_addr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ADDR_W+DATA_W-1:0]     out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic [CNT_W-1:0]             drop_count_o,
    output logic                         overflow_o,
    output logic [1:0]                   state_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_FROZEN  = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [ENTRY_W-1:0]   out_data_q;
    logic [CNT_W-1:0]     drop_q;
    logic                 overflow_q;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];

    // Next-state values
    logic [PTR_W-1:0]     wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_d;
    logic [LVL_W-1:0]     level_d;
    logic [ENTRY_W-1:0]   out_data_d;
    logic [CNT_W-1:0]     drop_d;
    logic                 overflow_d;

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    logic                 w_pass;
    logic                 w_qual;
    logic                 w_stop_hit;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_entry;

    generate
        if (FILTER_ZERO != 0) begin : g_filter_zero
            // Writes with a zero address or zero data are treated as noise.
            assign w_pass = (wr_addr_i != '0) && (wr_data_i != '0);
        end else begin : g_filter_none
            assign w_pass = 1'b1;
        end
    endgenerate

    assign w_qual     = wr_en_i && (state_q == ST_CAPTURE) && w_pass;
    assign w_stop_hit = w_qual && stop_en_i && (wr_addr_i == stop_addr_i);
    assign w_entry    = {wr_addr_i, wr_data_i};

    // Full/empty come from level so pointer equality is never ambiguous.
    assign w_full  = (level_q == LVL_FULL);
    assign w_pop   = out_valid_o && out_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = w_qual && (!w_full || w_pop);
    assign w_drop  = w_qual && w_full && !w_pop;

    // ------------------------------------------------------------------
    // FIFO next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_data_d = out_data_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // out_data is a registered copy of the next head. When the next head
        // is the entry being pushed this cycle, the RAM does not hold it yet,
        // so forward it from the write port. An empty FIFO keeps the last
        // value shown.
        if (level_d != '0) begin
            if (w_push && (rd_ptr_d == wr_ptr_q)) begin
                out_data_d = w_entry;
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end

        if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_q != CNT_MAX) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array (no reset needed: contents are qualified by level)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    // ------------------------------------------------------------------
    // Control registers and capture state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            // clear takes priority over arm arriving in the same cycle
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_data_q <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_data_q <= out_data_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;

            case (state_q)
                ST_IDLE: begin
                    if (arm_i) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // The stopping write itself is still recorded above.
                    if (w_stop_hit) begin
                        state_q <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    // Resume without flushing the captured entries.
                    if (arm_i) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all derived from registers only)
    // ------------------------------------------------------------------
    assign out_valid_o  = (level_q != '0);
    assign out_data_o   = out_data_q;
    assign level_o      = level_q;
    assign drop_count_o = drop_q;
    assign overflow_o   = overflow_q;
    assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_tracer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_write_tracer
// Purpose  : Self-checking bench for mem_write_tracer. Directed scenarios
//            plus a randomized run compared against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_write_tracer;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int E_W    = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              arm = 1'b0;
    logic              clear = 1'b0;
    logic              stop_en = 1'b0;
    logic [ADDR_W-1:0] stop_addr = '0;
    logic              out_ready = 1'b0;

    logic              out_valid,   nf_out_valid;
    logic [E_W-1:0]    out_data,    nf_out_data;
    logic [4:0]        level,       nf_level;
    logic [CNT_W-1:0]  drop_count,  nf_drop_count;
    logic              overflow,    nf_overflow;
    logic [1:0]        state,       nf_state;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the filtering DUT
    logic [E_W-1:0]   mq[$];
    int               m_state = 0;
    logic [CNT_W-1:0] m_drop = '0;
    logic             m_ovf = 1'b0;
    logic [E_W-1:0]   m_out = '0;

    always #5 clk = ~clk;

    mem_write_tracer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                       .FILTER_ZERO(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .arm_i(arm), .clear_i(clear), .stop_en_i(stop_en),
        .stop_addr_i(stop_addr), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .level_o(level), .drop_count_o(drop_count),
        .overflow_o(overflow), .state_o(state)
    );

    mem_write_tracer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                       .FILTER_ZERO(0), .CNT_W(CNT_W)) dut_nf (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .arm_i(arm), .clear_i(clear), .stop_en_i(stop_en),
        .stop_addr_i(stop_addr), .out_valid_o(nf_out_valid), .out_ready_i(out_ready),
        .out_data_o(nf_out_data), .level_o(nf_level), .drop_count_o(nf_drop_count),
        .overflow_o(nf_overflow), .state_o(nf_state)
    );

    // Advance the model by the rules for the current inputs, then clock once
    // and land 1 time unit after the edge.
    task automatic step();
        bit q, pop, full;
        if (reset || clear) begin
            mq.delete();
            m_state = 0;
            m_drop  = '0;
            m_ovf   = 1'b0;
            m_out   = '0;
        end else begin
            pop  = (mq.size() != 0) && out_ready;
            full = (mq.size() == DEPTH);
            q    = wr_en && (m_state == 1) && (wr_addr != 0) && (wr_data != 0);
            if (pop) void'(mq.pop_front());
            if (q) begin
                if (!full || pop) mq.push_back({wr_addr, wr_data});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != {CNT_W{1'b1}}) m_drop = m_drop + 1'b1;
                end
            end
            case (m_state)
                0: if (arm) m_state = 1;
                1: if (q && stop_en && wr_addr == stop_addr) m_state = 2;
                default: if (arm) m_state = 1;
            endcase
            if (mq.size() != 0) m_out = mq[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_clear_arm();
        clear = 1'b1; step(); clear = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        n_cmp += 6;
        if (state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %h expected 0", state); end
        if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (out_data !== 40'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", out_data); end
        if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_basic();
        arm = 1'b1; step(); arm = 1'b0;
        n_cmp++;
        if (state !== 2'b01) begin n_err++; $display("FAIL basic_arm: got %h expected 1", state); end
        out_ready = 1'b1;
        write(16'h0010, 24'h0000AB);
        n_cmp += 3;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        if (out_data !== 40'h00100000AB) begin n_err++; $display("FAIL basic_data: got %h expected 00100000ab", out_data); end
        if (level !== 5'd1) begin n_err++; $display("FAIL basic_level1: got %0d expected 1", level); end
        step();
        n_cmp += 3;
        if (level !== 5'd0) begin n_err++; $display("FAIL basic_level0: got %0d expected 0", level); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drained: got %b expected 0", out_valid); end
        if (out_data !== 40'h00100000AB) begin n_err++; $display("FAIL basic_hold: got %h expected 00100000ab", out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_filter();
        out_ready = 1'b0;
        do_clear_arm();
        write(16'h0000, 24'h000005);
        write(16'h0007, 24'h000000);
        n_cmp += 4;
        if (level !== 5'd0) begin n_err++; $display("FAIL filter_level: got %0d expected 0", level); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL filter_valid: got %b expected 0", out_valid); end
        if (nf_level !== 5'd2) begin n_err++; $display("FAIL nofilter_level: got %0d expected 2", nf_level); end
        if (nf_out_data !== 40'h0000000005) begin n_err++; $display("FAIL nofilter_head0: got %h expected 0000000005", nf_out_data); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_cmp += 2;
        if (nf_out_data !== 40'h0007000000) begin n_err++; $display("FAIL nofilter_head1: got %h expected 0007000000", nf_out_data); end
        if (nf_level !== 5'd1) begin n_err++; $display("FAIL nofilter_level1: got %0d expected 1", nf_level); end
    endtask

    task automatic test_overflow();
        logic [E_W-1:0] exp_e;
        out_ready = 1'b0;
        do_clear_arm();
        for (int i = 0; i < 20; i++) write(ADDR_W'(i + 1), DATA_W'(24'h100 + i));
        n_cmp += 4;
        if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d expected 16", level); end
        if (drop_count !== 16'd4) begin n_err++; $display("FAIL ovf_drop: got %0d expected 4", drop_count); end
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_e = {ADDR_W'(i + 1), DATA_W'(24'h100 + i)};
            n_cmp++;
            if (out_data !== exp_e) begin n_err++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, out_data, exp_e); end
            step();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (level !== 5'd0) begin n_err++; $display("FAIL ovf_empty: got %0d expected 0", level); end
    endtask

    task automatic test_full_pushpop();
        out_ready = 1'b0;
        do_clear_arm();
        for (int i = 0; i < 16; i++) write(ADDR_W'(16'h200 + i), DATA_W'(24'h1000 + i));
        n_cmp++;
        if (level !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d expected 16", level); end
        out_ready = 1'b1;
        write(16'h0300, 24'h002000);
        n_cmp += 4;
        if (level !== 5'd16) begin n_err++; $display("FAIL pushpop_level: got %0d expected 16", level); end
        if (drop_count !== 16'd0) begin n_err++; $display("FAIL pushpop_drop: got %0d expected 0", drop_count); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL pushpop_ovf: got %b expected 0", overflow); end
        if (out_data !== 40'h0201001001) begin n_err++; $display("FAIL pushpop_head: got %h expected 0201001001", out_data); end
        for (int i = 0; i < 15; i++) step();
        n_cmp += 2;
        if (out_data !== 40'h0300002000) begin n_err++; $display("FAIL pushpop_tail: got %h expected 0300002000", out_data); end
        if (level !== 5'd1) begin n_err++; $display("FAIL pushpop_tail_level: got %0d expected 1", level); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_stop();
        out_ready = 1'b0;
        do_clear_arm();
        stop_en = 1'b1; stop_addr = 16'h0040;
        write(16'h003F, 24'h000001);
        write(16'h0040, 24'h000002);
        n_cmp++;
        if (state !== 2'b10) begin n_err++; $display("FAIL stop_frozen: got %h expected 2", state); end
        write(16'h0041, 24'h000003);
        n_cmp += 3;
        if (level !== 5'd2) begin n_err++; $display("FAIL stop_level: got %0d expected 2", level); end
        if (state !== 2'b10) begin n_err++; $display("FAIL stop_hold: got %h expected 2", state); end
        if (out_data !== 40'h003F000001) begin n_err++; $display("FAIL stop_head: got %h expected 003f000001", out_data); end
        arm = 1'b1; step(); arm = 1'b0;
        n_cmp += 2;
        if (state !== 2'b01) begin n_err++; $display("FAIL stop_rearm: got %h expected 1", state); end
        if (level !== 5'd2) begin n_err++; $display("FAIL stop_kept: got %0d expected 2", level); end
        write(16'h0050, 24'h000004);
        n_cmp++;
        if (level !== 5'd3) begin n_err++; $display("FAIL stop_resume: got %0d expected 3", level); end
        stop_en = 1'b0;
    endtask

    task automatic test_clear_arm();
        out_ready = 1'b0;
        do_clear_arm();
        for (int i = 0; i < 5; i++) write(ADDR_W'(16'h10 + i), DATA_W'(24'h55 + i));
        n_cmp++;
        if (level !== 5'd5) begin n_err++; $display("FAIL clr_prefill: got %0d expected 5", level); end
        clear = 1'b1; arm = 1'b1; step(); clear = 1'b0; arm = 1'b0;
        n_cmp += 5;
        if (state !== 2'b00) begin n_err++; $display("FAIL clr_state: got %h expected 0", state); end
        if (level !== 5'd0) begin n_err++; $display("FAIL clr_level: got %0d expected 0", level); end
        if (drop_count !== 16'd0) begin n_err++; $display("FAIL clr_drop: got %0d expected 0", drop_count); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b expected 0", out_valid); end
        if (out_data !== 40'h0) begin n_err++; $display("FAIL clr_data: got %h expected 0", out_data); end
    endtask

    task automatic test_wrap();
        logic [E_W-1:0] exp_e;
        arm = 1'b1; step(); arm = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            write(ADDR_W'(16'h400 + i), DATA_W'(24'h3000 + i));
            exp_e = {ADDR_W'(16'h400 + i), DATA_W'(24'h3000 + i)};
            n_cmp += 2;
            if (out_data !== exp_e) begin n_err++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, out_data, exp_e); end
            if (level !== 5'd1) begin n_err++; $display("FAIL wrap_level[%0d]: got %0d expected 1", i, level); end
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_addr   = ($urandom_range(0, 7) == 0) ? 16'h0 : ADDR_W'($urandom_range(1, 16'h7F));
            wr_data   = ($urandom_range(0, 7) == 0) ? 24'h0 : DATA_W'($urandom);
            arm       = ($urandom_range(0, 15) == 0);
            clear     = ($urandom_range(0, 149) == 0);
            stop_en   = ($urandom_range(0, 3) == 0);
            stop_addr = 16'h0040;
            out_ready = ($urandom_range(0, 2) == 0);
            step();
            n_cmp += 6;
            if (state !== 2'(m_state)) begin n_err++; $display("FAIL rnd_state@%0d: got %h expected %h", c, state, 2'(m_state)); end
            if (level !== 5'(mq.size())) begin n_err++; $display("FAIL rnd_level@%0d: got %0d expected %0d", c, level, mq.size()); end
            if (out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, out_valid, mq.size() != 0); end
            if (out_data !== m_out) begin n_err++; $display("FAIL rnd_data@%0d: got %h expected %h", c, out_data, m_out); end
            if (drop_count !== m_drop) begin n_err++; $display("FAIL rnd_drop@%0d: got %0d expected %0d", c, drop_count, m_drop); end
            if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b expected %b", c, overflow, m_ovf); end
        end
        wr_en = 1'b0; arm = 1'b0; clear = 1'b0; stop_en = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_overflow();
        test_full_pushpop();
        test_stop();
        test_clear_arm();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
